// File: rtl/apb_delayer_scaled.sv
// APB latency injector placed between a master (in_*) and one slave (out_*).
// MODE 0 is a plain wire, MODE 1 scales the slave latency, MODE 2 adds a fixed delay.
module apb_delayer_scaled #(
   parameter int          ADDR_W    = 32,
   parameter int          DATA_W    = 32,
   parameter int          MODE      = 1,
   parameter logic [31:0] RATIO     = 32'h600,
   parameter int          FRAC      = 8,
   parameter int          FIXED_DLY = 4,
   parameter int          CNT_W     = 16
) (
   input  logic                clock,
   input  logic                reset_n,
   input  logic [ADDR_W-1:0]   in_paddr,
   input  logic                in_psel,
   input  logic                in_penable,
   input  logic [2:0]          in_pprot,
   input  logic                in_pwrite,
   input  logic [DATA_W-1:0]   in_pwdata,
   input  logic [DATA_W/8-1:0] in_pstrb,
   output logic                in_pready,
   output logic [DATA_W-1:0]   in_prdata,
   output logic                in_pslverr,
   output logic [ADDR_W-1:0]   out_paddr,
   output logic                out_psel,
   output logic                out_penable,
   output logic [2:0]          out_pprot,
   output logic                out_pwrite,
   output logic [DATA_W-1:0]   out_pwdata,
   output logic [DATA_W/8-1:0] out_pstrb,
   input  logic                out_pready,
   input  logic [DATA_W-1:0]   out_prdata,
   input  logic                out_pslverr,
   output logic [1:0]          dbg_state
);

   // Handshake: the slave completes a transfer in the one IDLE/DS cycle where
   // out_psel && out_penable && out_pready; the master completes in the single
   // RESP cycle where in_pready = 1, with prdata/pslverr valid only then.
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_DS   = 2'd1,
      S_HOLD = 2'd2,
      S_RESP = 2'd3
   } state_t;

   localparam int               PW      = CNT_W + 32;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  n_q, n_d;
   logic [CNT_W-1:0]  h_q, h_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              slverr_q, slverr_d;

   logic              access;
   logic              capture;
   logic              fwd;
   logic [CNT_W-1:0]  n_inc;
   logic [PW-1:0]     prod;
   logic [PW-1:0]     scaled;
   logic [CNT_W:0]    fixed_sum;
   logic [CNT_W-1:0]  tgt;
   logic [CNT_W:0]    c_plus1;
   logic [CNT_W:0]    n_tot;
   logic [CNT_W-1:0]  hold_cnt;

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q  <= S_IDLE;
         n_q      <= CNT_ONE;
         h_q      <= '0;
         rdata_q  <= '0;
         slverr_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         n_q      <= n_d;
         h_q      <= h_d;
         rdata_q  <= rdata_d;
         slverr_q <= slverr_d;
      end
   end

   // n_q always holds the number of the current access cycle (1 while IDLE).
   always_comb begin
      access    = in_psel && in_penable;
      capture   = access && out_pready && ((state_q == S_IDLE) || (state_q == S_DS));
      n_inc     = (n_q == CNT_MAX) ? n_q : n_q + CNT_ONE;
      prod      = PW'(n_q) * PW'(RATIO);
      scaled    = prod >> FRAC;
      fixed_sum = {1'b0, n_q} + (CNT_W+1)'(FIXED_DLY);
      if (MODE == 2) begin
         tgt = fixed_sum[CNT_W] ? CNT_MAX : fixed_sum[CNT_W-1:0];
      end else begin
         tgt = (|scaled[PW-1:CNT_W]) ? CNT_MAX : scaled[CNT_W-1:0];
      end
      c_plus1  = {1'b0, n_q} + (CNT_W+1)'(1);
      n_tot    = ({1'b0, tgt} > c_plus1) ? {1'b0, tgt} : c_plus1;
      hold_cnt = CNT_W'(n_tot - c_plus1);
   end

   always_comb begin
      state_d  = state_q;
      n_d      = n_q;
      h_d      = h_q;
      rdata_d  = rdata_q;
      slverr_d = slverr_q;
      if (MODE != 0) begin
         case (state_q)
            S_IDLE, S_DS: begin
               if ((state_q == S_DS) && !in_psel) begin
                  state_d  = S_IDLE;
                  n_d      = CNT_ONE;
                  h_d      = '0;
                  rdata_d  = '0;
                  slverr_d = 1'b0;
               end else if (capture) begin
                  state_d  = (hold_cnt == '0) ? S_RESP : S_HOLD;
                  n_d      = CNT_ONE;
                  h_d      = hold_cnt;
                  rdata_d  = out_prdata;
                  slverr_d = out_pslverr;
               end else if (access) begin
                  state_d = S_DS;
                  n_d     = n_inc;
               end
            end
            S_HOLD: begin
               if (!in_psel) begin
                  state_d  = S_IDLE;
                  h_d      = '0;
                  rdata_d  = '0;
                  slverr_d = 1'b0;
               end else if (h_q <= CNT_ONE) begin
                  state_d = S_RESP;
                  h_d     = '0;
               end else begin
                  h_d = h_q - CNT_ONE;
               end
            end
            S_RESP: begin
               state_d  = S_IDLE;
               n_d      = CNT_ONE;
               h_d      = '0;
               rdata_d  = '0;
               slverr_d = 1'b0;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // The slave only sees the request while the transfer is still downstream.
   always_comb begin
      out_paddr  = in_paddr;
      out_pprot  = in_pprot;
      out_pwrite = in_pwrite;
      out_pwdata = in_pwdata;
      out_pstrb  = in_pstrb;
      dbg_state  = state_q;
      fwd        = (state_q == S_IDLE) || (state_q == S_DS);
      if (MODE == 0) begin
         out_psel    = in_psel;
         out_penable = in_penable;
         in_pready   = out_pready;
         in_prdata   = out_prdata;
         in_pslverr  = out_pslverr;
      end else begin
         out_psel    = in_psel && fwd;
         out_penable = in_penable && fwd;
         in_pready   = (state_q == S_RESP);
         in_prdata   = (state_q == S_RESP) ? rdata_q : '0;
         in_pslverr  = (state_q == S_RESP) && slverr_q;
      end
   end

endmodule

// File: tb/tb_apb_delayer_scaled.sv
// Bench for apb_delayer_scaled: six instances with different modes/ratios share
// one master and one slave model; only the selected instance receives psel.
module tb_apb_delayer_scaled;

   localparam int          NK                 = 6;
   localparam int          MODE_T  [NK]       = '{1, 1, 2, 0, 1, 1};
   localparam logic [31:0] RATIO_T [NK]       = '{32'h600, 32'h180, 32'h600, 32'h600, 32'h200, 32'h600};
   localparam int          CNTW_T  [NK]       = '{16, 16, 16, 16, 16, 4};
   localparam int          FIXED              = 4;
   localparam logic [1:0]  ST_IDLE = 2'd0, ST_DS = 2'd1, ST_HOLD = 2'd2;

   typedef struct {
      int          k;
      bit          wr;
      int          c;
      bit          err;
      logic [31:0] data;
      bit          b2b;
      int          exp_n;
   } vec_t;

   // clock / reset
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   // master side
   int          cur_k;
   logic        m_psel, m_penable, pwrite;
   logic [31:0] paddr, pwdata;
   logic [2:0]  pprot;
   logic [3:0]  pstrb;
   // slave side
   logic        s_pready, s_pslverr;
   logic [31:0] s_prdata;

   logic        psel_a     [NK];
   logic        pready_a   [NK];
   logic [31:0] prdata_a   [NK];
   logic        pslverr_a  [NK];
   logic [31:0] o_paddr_a  [NK];
   logic        o_psel_a   [NK];
   logic        o_penable_a[NK];
   logic [2:0]  o_pprot_a  [NK];
   logic        o_pwrite_a [NK];
   logic [31:0] o_pwdata_a [NK];
   logic [3:0]  o_pstrb_a  [NK];
   logic [1:0]  dbg_a      [NK];

   for (genvar g = 0; g < NK; g++) begin : g_dut
      assign psel_a[g] = m_psel && (cur_k == g);
      apb_delayer_scaled #(
         .ADDR_W(32), .DATA_W(32), .MODE(MODE_T[g]), .RATIO(RATIO_T[g]),
         .FRAC(8), .FIXED_DLY(FIXED), .CNT_W(CNTW_T[g])
      ) u_dut (
         .clock(clk), .reset_n(rst_n),
         .in_paddr(paddr), .in_psel(psel_a[g]), .in_penable(m_penable),
         .in_pprot(pprot), .in_pwrite(pwrite), .in_pwdata(pwdata), .in_pstrb(pstrb),
         .in_pready(pready_a[g]), .in_prdata(prdata_a[g]), .in_pslverr(pslverr_a[g]),
         .out_paddr(o_paddr_a[g]), .out_psel(o_psel_a[g]), .out_penable(o_penable_a[g]),
         .out_pprot(o_pprot_a[g]), .out_pwrite(o_pwrite_a[g]), .out_pwdata(o_pwdata_a[g]),
         .out_pstrb(o_pstrb_a[g]),
         .out_pready(s_pready), .out_prdata(s_prdata), .out_pslverr(s_pslverr),
         .dbg_state(dbg_a[g])
      );
   end

   // scoreboard
   int          n_checks = 0;
   int          n_pass   = 0;
   logic [31:0] exp_q[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Reference: access cycle in which the master sees pready, from the latency rules.
   function automatic int exp_cycles(input int k, input int c);
      longint cmax, ce, t, n;
      if (MODE_T[k] == 0) return c;
      cmax = (longint'(1) << CNTW_T[k]) - 1;
      ce   = (c > cmax) ? cmax : longint'(c);
      if (MODE_T[k] == 1) t = (ce * longint'(RATIO_T[k])) >> 8;
      else                t = ce + FIXED;
      if (t > cmax) t = cmax;
      n = (t > ce + 1) ? t : ce + 1;
      return int'(longint'(c) + n - ce);
   endfunction

   // driver tasks
   task automatic slave_idle();
      s_pready  = 1'b0;
      s_prdata  = '0;
      s_pslverr = 1'b0;
   endtask

   task automatic xfer(input int k, input bit wr, input int c, input bit err, input logic [31:0] data,
                       input bit skip_setup, input bit next_b2b,
                       output int n_obs, output logic [31:0] rd_obs, output logic err_obs,
                       output int s_cnt, output int late, output bit after_ok);
      int seen;
      bit cap;
      bit hit;
      cur_k  = k;
      pwrite = wr;
      pwdata = $urandom;
      pprot  = 3'($urandom);
      pstrb  = 4'hF;
      if (!skip_setup) begin
         @(negedge clk);
         m_psel    = 1'b1;
         m_penable = 1'b0;
         paddr     = $urandom;
         slave_idle();
      end
      seen = 0; cap = 1'b0; n_obs = -1; rd_obs = '0; err_obs = 1'b0; s_cnt = 0; late = 0;
      for (int cyc = 1; cyc <= 200 && n_obs < 0; cyc++) begin
         @(negedge clk);
         m_penable = 1'b1;
         #1;
         hit = 1'b0;
         if (o_psel_a[k] && o_penable_a[k]) begin
            if (cap) late++;
            else seen++;
            hit = !cap && (seen == c);
         end
         s_pready  = hit;
         s_prdata  = hit ? data : $urandom;
         s_pslverr = hit ? err : 1'($urandom);
         #1;
         if (hit) s_cnt++;
         if (pready_a[k] === 1'b1) begin
            n_obs   = cyc;
            rd_obs  = prdata_a[k];
            err_obs = pslverr_a[k];
         end
         if (hit) cap = 1'b1;
      end
      @(negedge clk);
      m_psel    = next_b2b;
      m_penable = 1'b0;
      if (next_b2b) paddr = $urandom;
      slave_idle();
      #2;
      after_ok = (pready_a[k] === 1'b0) && (prdata_a[k] === '0) && (pslverr_a[k] === 1'b0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        vecs[10];
      int          n_obs, s_cnt, late, got, k, c;
      logic [31:0] rd, data, e_n, e_d, e_e;
      logic        er;
      bit          after_ok, skip, wr, err;

      vecs[0] = '{0, 1'b0, 1,  1'b0, 32'hA5A5_0001, 1'b0, 6};
      vecs[1] = '{1, 1'b0, 3,  1'b0, 32'hA5A5_0002, 1'b0, 4};
      vecs[2] = '{1, 1'b0, 1,  1'b0, 32'hA5A5_0003, 1'b0, 2};
      vecs[3] = '{2, 1'b1, 2,  1'b1, 32'hA5A5_0004, 1'b0, 6};
      vecs[4] = '{3, 1'b0, 1,  1'b0, 32'hA5A5_0005, 1'b0, 1};
      vecs[5] = '{3, 1'b0, 3,  1'b1, 32'hA5A5_0006, 1'b0, 3};
      vecs[6] = '{4, 1'b0, 1,  1'b0, 32'h1111_1111, 1'b1, 2};
      vecs[7] = '{4, 1'b0, 3,  1'b0, 32'h2222_2222, 1'b0, 6};
      vecs[8] = '{5, 1'b0, 20, 1'b0, 32'hA5A5_0009, 1'b0, 21};
      vecs[9] = '{5, 1'b0, 2,  1'b0, 32'hA5A5_000A, 1'b0, 12};

      rst_n = 1'b0; cur_k = 0; m_psel = 1'b0; m_penable = 1'b0; pwrite = 1'b0;
      paddr = 32'h0000_1234; pwdata = '0; pprot = '0; pstrb = '0;
      slave_idle();
      repeat (3) @(negedge clk);
      #1;
      for (int i = 0; i < NK; i++) begin
         check($sformatf("reset_state_%0d", i),   dbg_a[i],     ST_IDLE);
         check($sformatf("reset_pready_%0d", i),  pready_a[i],  0);
         check($sformatf("reset_prdata_%0d", i),  prdata_a[i],  0);
         check($sformatf("reset_pslverr_%0d", i), pslverr_a[i], 0);
      end
      m_psel = 1'b1;
      #1;
      check("reset_idle_psel_pass", o_psel_a[0], 1);
      check("reset_idle_paddr_pass", o_paddr_a[0], 32'h0000_1234);
      m_psel = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // directed table
      skip = 1'b0;
      for (int i = 0; i < 10; i++) begin
         xfer(vecs[i].k, vecs[i].wr, vecs[i].c, vecs[i].err, vecs[i].data, skip, vecs[i].b2b,
              n_obs, rd, er, s_cnt, late, after_ok);
         check($sformatf("vec%0d_cycle", i),   n_obs, vecs[i].exp_n);
         check($sformatf("vec%0d_prdata", i),  rd, vecs[i].data);
         check($sformatf("vec%0d_pslverr", i), er, vecs[i].err);
         check($sformatf("vec%0d_slave_xfers", i), s_cnt, 1);
         check($sformatf("vec%0d_psel_after_capture", i), late, 0);
         check($sformatf("vec%0d_idle_after", i), after_ok, 1);
         skip = vecs[i].b2b;
      end

      // abort while holding: drop psel in the first HOLD cycle
      cur_k = 0;
      @(negedge clk); m_psel = 1'b1; m_penable = 1'b0; slave_idle();
      @(negedge clk); m_penable = 1'b1; #1;
      s_pready = 1'b1; s_prdata = 32'hDEAD_0001; s_pslverr = 1'b0;
      @(negedge clk); slave_idle(); #1;
      check("abort_hold_state", dbg_a[0], ST_HOLD);
      m_psel = 1'b0; m_penable = 1'b0; #1;
      check("abort_hold_out_psel", o_psel_a[0], 0);
      got = 0;
      repeat (8) begin
         @(negedge clk); #1;
         if (pready_a[0] !== 1'b0) got++;
      end
      check("abort_no_pready", got, 0);
      check("abort_state_idle", dbg_a[0], ST_IDLE);
      check("abort_prdata_clear", prdata_a[0], 0);
      xfer(0, 1'b0, 2, 1'b0, 32'h0BAD_F00D, 1'b0, 1'b0, n_obs, rd, er, s_cnt, late, after_ok);
      check("post_abort_cycle", n_obs, 12);
      check("post_abort_prdata", rd, 32'h0BAD_F00D);

      // reset while the slave access is in progress
      cur_k = 1;
      @(negedge clk); m_psel = 1'b1; m_penable = 1'b0; slave_idle();
      @(negedge clk); m_penable = 1'b1;
      @(negedge clk); #1;
      check("rst_ds_state", dbg_a[1], ST_DS);
      rst_n = 1'b0;
      @(negedge clk); #1;
      check("rst_ds_pready", pready_a[1], 0);
      check("rst_ds_prdata", prdata_a[1], 0);
      check("rst_ds_pslverr", pslverr_a[1], 0);
      check("rst_ds_state_idle", dbg_a[1], ST_IDLE);
      rst_n = 1'b1; m_psel = 1'b0; m_penable = 1'b0;
      @(negedge clk);
      xfer(1, 1'b0, 3, 1'b0, 32'h5EED_0003, 1'b0, 1'b0, n_obs, rd, er, s_cnt, late, after_ok);
      check("post_reset_cycle", n_obs, 4);
      check("post_reset_prdata", rd, 32'h5EED_0003);

      // randomized transfers against the reference
      for (int i = 0; i < 40; i++) begin
         k    = $urandom_range(0, NK - 1);
         c    = (k == 5) ? $urandom_range(1, 20) : $urandom_range(1, 8);
         wr   = 1'($urandom);
         err  = 1'($urandom);
         data = $urandom;
         exp_q.push_back(32'(exp_cycles(k, c)));
         exp_q.push_back(data);
         exp_q.push_back(32'(err));
         xfer(k, wr, c, err, data, 1'b0, 1'b0, n_obs, rd, er, s_cnt, late, after_ok);
         e_n = exp_q.pop_front();
         e_d = exp_q.pop_front();
         e_e = exp_q.pop_front();
         check($sformatf("rand%0d_k%0d_c%0d_cycle", i, k, c), n_obs, e_n);
         check($sformatf("rand%0d_prdata", i), rd, e_d);
         check($sformatf("rand%0d_pslverr", i), er, e_e[0]);
         check($sformatf("rand%0d_slave_xfers", i), s_cnt, 1);
         check($sformatf("rand%0d_idle_after", i), after_ok, 1);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/apb_delayer_scaled.md
# apb_delayer_scaled

Parametrised APB latency injector between an APB master (in_*) and a slave (out_*). It emulates a slower peripheral clock domain by stretching each transfer.
- Proportional mode: observed slave latency is scaled by a fixed-point ratio.
- Fixed mode: a constant number of cycles is added.
- Bypass mode: the block is a wire.

The response is registered and there are no latches. The block sits on each peripheral APB branch of the SoC bus.

## Interface
- ADDR_W, 32, paddr width
- DATA_W, 32, pwdata/prdata width; pstrb width is DATA_W/8
- MODE, 1, 0 = bypass, 1 = proportional, 2 = fixed extra delay
- RATIO, 32'h600, Q(·).FRAC ratio, target latency per downstream cycle (0x600 = 6.0)
- FRAC, 8, fractional bits of RATIO
- FIXED_DLY, 4, extra cycles in MODE 2
- CNT_W, 16, latency counter width
- clock  in  1  sole clock
- reset_n  in  1  synchronous, active-low reset
- in_paddr/in_psel/in_penable/in_pprot(3)/in_pwrite/in_pwdata/in_pstrb  in  master request
- in_pready  out  1  registered ready to master
- in_prdata  out  DATA_W  captured read data, 0 when in_pready=0
- in_pslverr  out  1  captured error, 0 when in_pready=0
- out_paddr/out_pprot/out_pwrite/out_pwdata/out_pstrb  out  combinational copies of in_*
- out_psel, out_penable  out  1  gated request to slave
- out_pready, out_prdata, out_pslverr  in  slave response

## Operation
- MODE 0: all signals pass straight through; no state is used.
- States for MODE 1/2:
  - IDLE: out_psel = in_psel, out_penable = in_penable. Counter n is loaded with 1 while in_psel && in_penable.
  - DS: downstream access in progress, with out_psel/out_penable mirrored. While !out_pready, n increments, saturating at 2^CNT_W−1.
  - HOLD: out_psel = out_penable = 0. Counter h counts down to 0.
  - RESP: in_pready = 1 for exactly one cycle.
- The access phase begins when in_psel && in_penable. Capture happens on the cycle out_pready = 1.
- At capture:
  - Register prdata and pslverr.
  - Take c = n, the number of access cycles including the ready cycle.
  - Compute the target T:
    - MODE 1: T = (c·RATIO) >> FRAC. Use a full-width CNT_W+32 product, floor it, then saturate to CNT_W bits.
    - MODE 2: T = c + FIXED_DLY, saturating.
  - Compute N = max(T, c+1). The master sees in_pready in its N-th access cycle.
  - Load h = N − c − 1. If h = 0, go DS→RESP; otherwise go DS→HOLD.
- HOLD→RESP when h reaches 1, with h decrementing each cycle.
- RESP→IDLE unconditionally. On the next cycle in_pready returns to 0 and in_prdata/in_pslverr return to 0.
- out_pready is ignored outside DS. The slave sees exactly one completed transfer per master transfer.
- Protocol abort: if in_psel = 0 in DS or HOLD, return to IDLE immediately. No in_pready is given and captured data is cleared.
- Back-to-back transfers: a new setup phase in the cycle after RESP is accepted normally from IDLE.

## Timing
- Reset (reset_n = 0 at a clock edge) puts the state in IDLE with n = 1 and h = 0.
  - in_pready, in_prdata and in_pslverr are 0.
  - out_psel/out_penable follow in_* combinationally, since IDLE is a passthrough.
- Reset asserted mid-transfer aborts it. No in_pready is emitted.
- Minimum added latency in MODE 1/2 is 1 cycle, because the response is registered.
- MODE 1 with RATIO ≤ 1<<FRAC gives N = c+1.
- The upstream address, data and control signals must stay stable until in_pready; this is the APB rule, and the block does not re-register them.
- Saturation: with c = 2^CNT_W−1, T saturates. The transfer still completes with a finite N.

## Test plan
- MODE 1, RATIO = 0x600:
  - Slave ready in its 1st access cycle (c = 1) → T = 6. in_pready is high in the 6th access cycle only, in_prdata = slave data, out_psel is low in cycles 2–6.
- MODE 1, RATIO = 0x180 (1.5):
  - Slave waits 2 cycles (c = 3) → T = 4. in_pready in access cycle 4.
  - c = 1 → T = 1, so N = 2.
- MODE 2, FIXED_DLY = 4:
  - Write with c = 2 and out_pslverr = 1 → in_pready in access cycle 6 with in_pslverr = 1, then both are 0 the cycle after.
- MODE 0:
  - in_pready tracks out_pready in the same cycle.
  - in_prdata = out_prdata combinationally, with zero added cycles.
- Abort and reset:
  - Drop in_psel during HOLD → state returns to IDLE, no in_pready.
  - Assert reset_n = 0 during DS → all in_* outputs are 0 next cycle.
  - A following normal transfer then completes with the correct N.
- Back-to-back:
  - Two reads with c = 1 and c = 3 at RATIO = 0x200 → N = 2 and N = 6. Each is captured with its own data, with no leakage of data from the first read.
